// File: rtl/evr_pulse_gen_if.sv
// Configuration, event and status bundle between the EVR/MMR side and the
// pulse generator. The master side drives events and configuration and reads
// back the trigger outputs and per-channel status.
interface evr_pulse_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DLY_W  = 32,
    parameter int WID_W  = 16
);
    logic [7:0]              ev;
    logic                    ena;
    logic [NUM_CH-1:0]       ch_ena;
    logic [NUM_CH*8-1:0]     ch_code;
    logic [NUM_CH*DLY_W-1:0] ch_delay;
    logic [NUM_CH*WID_W-1:0] ch_width;
    logic [NUM_CH-1:0]       ch_pol;
    logic [NUM_CH-1:0]       missed_clr;
    logic [NUM_CH-1:0]       trig_out;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       missed;

    modport master (
        output ev, ena, ch_ena, ch_code, ch_delay, ch_width, ch_pol, missed_clr,
        input  trig_out, busy, missed
    );

    modport slave (
        input  ev, ena, ch_ena, ch_code, ch_delay, ch_width, ch_pol, missed_clr,
        output trig_out, busy, missed
    );
endinterface

// File: rtl/evr_pulse_gen.sv
// Event-driven pulse generator: NUM_CH independent channels, each firing a
// pulse of programmable width a programmable number of cycles after its event
// code is seen on the EVR event stream.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a matching event code
// DELAY  | trigger accepted, dly_cnt counting down to the pulse start
// ACTIVE | pulse in progress, wid_cnt counting down to the pulse end
//
// The FSM state is internal; pulse_q and busy_q are registered views of it
// one edge later, except that an abort clears them on the aborting edge.
module evr_pulse_gen #(
    parameter int NUM_CH = 4,
    parameter int DLY_W  = 32,
    parameter int WID_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    evr_pulse_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state_q, state_nxt;
        logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_nxt;
        logic [WID_W-1:0]   wid_cnt_q, wid_cnt_nxt;
        logic               pulse_q, pulse_nxt;
        logic               busy_q, busy_nxt;
        logic               miss_hit, miss_set_q, miss_clr_q, missed_q;
        logic [7:0]         code;
        logic [DLY_W-1:0]   delay;
        logic [WID_W-1:0]   width;
        logic               match;
        logic               abort;

        assign code  = bus.ch_code[8*i +: 8];
        assign delay = bus.ch_delay[DLY_W*i +: DLY_W];
        assign width = bus.ch_width[WID_W*i +: WID_W];

        // A zero event code is idle and never matches, even against code 0.
        assign match = bus.ena & bus.ch_ena[i] & (bus.ev != 8'h00) & (bus.ev == code);

        // Only the per-channel enable aborts an in-flight pulse.
        assign abort = (state_q != IDLE) & ~bus.ch_ena[i];

        // State register, latched counters and registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                dly_cnt_q <= '0;
                wid_cnt_q <= '0;
                pulse_q   <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                state_q   <= state_nxt;
                dly_cnt_q <= dly_cnt_nxt;
                wid_cnt_q <= wid_cnt_nxt;
                pulse_q   <= pulse_nxt;
                busy_q    <= busy_nxt;
            end
        end

        // Next-state, counter and retrigger-detect logic.
        always_comb begin
            state_nxt   = state_q;
            dly_cnt_nxt = dly_cnt_q;
            wid_cnt_nxt = wid_cnt_q;
            miss_hit    = 1'b0;
            case (state_q)
                IDLE: begin
                    // A zero width is a silent no-op rather than a dropped trigger.
                    if (match && (width != '0)) begin
                        dly_cnt_nxt = delay;
                        wid_cnt_nxt = width;
                        state_nxt   = (delay == '0) ? ACTIVE : DELAY;
                    end
                end
                DELAY: begin
                    if (abort) begin
                        state_nxt   = IDLE;
                        dly_cnt_nxt = '0;
                        wid_cnt_nxt = '0;
                    end else begin
                        miss_hit    = match;
                        dly_cnt_nxt = dly_cnt_q - DLY_W'(1);
                        if (dly_cnt_q == DLY_W'(1)) begin
                            state_nxt = ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (abort) begin
                        state_nxt   = IDLE;
                        dly_cnt_nxt = '0;
                        wid_cnt_nxt = '0;
                    end else begin
                        miss_hit    = match;
                        wid_cnt_nxt = wid_cnt_q - WID_W'(1);
                        if (wid_cnt_q == WID_W'(1)) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    dly_cnt_nxt = '0;
                    wid_cnt_nxt = '0;
                end
            endcase
            pulse_nxt = (state_q == ACTIVE) && !abort;
            busy_nxt  = (state_q != IDLE) && !abort;
        end

        // Sticky missed flag: set and clear both take effect one edge after
        // they are sampled, so a simultaneous pair resolves with set winning.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                miss_set_q <= 1'b0;
                miss_clr_q <= 1'b0;
                missed_q   <= 1'b0;
            end else begin
                miss_set_q <= miss_hit;
                miss_clr_q <= bus.missed_clr[i];
                missed_q   <= miss_set_q | (missed_q & ~miss_clr_q);
            end
        end

        assign bus.trig_out[i] = pulse_q ^ bus.ch_pol[i];
        assign bus.busy[i]     = busy_q;
        assign bus.missed[i]   = missed_q;
    end

endmodule

// File: tb/tb_evr_pulse_gen.sv
// Bench for evr_pulse_gen: directed scenarios followed by randomized traffic,
// all compared every cycle against a window-based reference model.
module tb_evr_pulse_gen;
    localparam int NUM_CH = 4;
    localparam int DLY_W  = 32;
    localparam int WID_W  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    evr_pulse_gen_if #(.NUM_CH(NUM_CH), .DLY_W(DLY_W), .WID_W(WID_W)) bus ();

    evr_pulse_gen #(.NUM_CH(NUM_CH), .DLY_W(DLY_W), .WID_W(WID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: each accepted trigger is a window of edge numbers.
    // busy over [acc+1, end], pulse over [start, end]; an abort truncates end.
    longint m_acc   [NUM_CH];
    longint m_start [NUM_CH];
    longint m_end   [NUM_CH];
    bit     m_valid [NUM_CH];
    bit     m_missed[NUM_CH];
    bit     m_set_p [NUM_CH];
    bit     m_clr_p [NUM_CH];

    logic [7:0] code_set [4] = '{8'h00, 8'h11, 8'h22, 8'h33};

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_valid[i]  = 1'b0;
            m_acc[i]    = 0;
            m_start[i]  = 0;
            m_end[i]    = 0;
            m_missed[i] = 1'b0;
            m_set_p[i]  = 1'b0;
            m_clr_p[i]  = 1'b0;
        end
    endfunction

    task automatic model_edge();
        longint e;
        cyc++;
        e = longint'(cyc);
        for (int i = 0; i < NUM_CH; i++) begin
            logic [7:0]       code;
            logic [DLY_W-1:0] d;
            logic [WID_W-1:0] w;
            bit               engaged;
            bit               match;
            code    = bus.ch_code[8*i +: 8];
            d       = bus.ch_delay[DLY_W*i +: DLY_W];
            w       = bus.ch_width[WID_W*i +: WID_W];
            engaged = m_valid[i] && (e >= m_acc[i] + 1) && (e <= m_end[i]);
            match   = bus.ena && bus.ch_ena[i] && (bus.ev != 8'h00) && (bus.ev == code);
            m_missed[i] = m_set_p[i] | (m_missed[i] & ~m_clr_p[i]);
            m_clr_p[i]  = bus.missed_clr[i];
            m_set_p[i]  = 1'b0;
            if (engaged && !bus.ch_ena[i]) begin
                m_end[i] = e - 1;
            end else if (match && engaged) begin
                m_set_p[i] = 1'b1;
            end else if (match && (w != '0)) begin
                m_valid[i] = 1'b1;
                m_acc[i]   = e;
                m_start[i] = e + 1 + longint'(d);
                m_end[i]   = m_start[i] + longint'(w) - 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [NUM_CH-1:0] obs,
                       input logic [NUM_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] e_trig, e_busy, e_miss;
        longint e;
        e = longint'(cyc);
        for (int i = 0; i < NUM_CH; i++) begin
            bit pulse;
            pulse     = m_valid[i] && (e >= m_start[i]) && (e <= m_end[i]);
            e_busy[i] = m_valid[i] && (e >= m_acc[i] + 1) && (e <= m_end[i]);
            e_trig[i] = pulse ^ bus.ch_pol[i];
            e_miss[i] = m_missed[i];
        end
        chk("trig_out", bus.trig_out, e_trig);
        chk("busy", bus.busy, e_busy);
        chk("missed", bus.missed, e_miss);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_ch(input int i, input logic [7:0] code, input logic [DLY_W-1:0] d,
                          input logic [WID_W-1:0] w, input logic pol);
        bus.ch_code[8*i +: 8]          = code;
        bus.ch_delay[DLY_W*i +: DLY_W] = d;
        bus.ch_width[WID_W*i +: WID_W] = w;
        bus.ch_pol[i]                  = pol;
    endtask

    task automatic fire(input logic [7:0] code);
        bus.ev = code;
        step();
        bus.ev = 8'h00;
    endtask

    // Reset asserted between edges: outputs must go inactive with no clock.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int c;

    initial begin
        rst            = 1'b1;
        bus.ev         = 8'h00;
        bus.ena        = 1'b1;
        bus.ch_ena     = '1;
        bus.ch_code    = '0;
        bus.ch_delay   = '0;
        bus.ch_width   = '0;
        bus.ch_pol     = '0;
        bus.missed_clr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all();

        // Basic delay/width timing on ch0.
        set_ch(0, 8'h20, 5, 3, 1'b0);
        fire(8'h20);
        steps(12);

        // Zero delay, then zero width.
        set_ch(0, 8'h21, 0, 1, 1'b0);
        fire(8'h21);
        steps(4);
        set_ch(0, 8'h21, 0, 0, 1'b0);
        fire(8'h21);
        steps(4);

        // Retrigger while busy, config change in flight, missed clear.
        set_ch(1, 8'h30, 10, 4, 1'b0);
        fire(8'h30);
        steps(2);
        set_ch(1, 8'h30, 2, 9, 1'b0);
        step();
        fire(8'h30);
        steps(15);
        bus.missed_clr[1] = 1'b1;
        step();
        bus.missed_clr[1] = 1'b0;
        steps(4);

        // Set and clear landing together: set wins.
        set_ch(1, 8'h30, 3, 3, 1'b0);
        fire(8'h30);
        bus.ev = 8'h30;
        bus.missed_clr[1] = 1'b1;
        step();
        bus.ev = 8'h00;
        steps(2);
        bus.missed_clr[1] = 1'b0;
        steps(6);

        // Back-to-back: event held every cycle, width 3 with no delay.
        set_ch(0, 8'h40, 0, 3, 1'b0);
        bus.ev = 8'h40;
        steps(9);
        bus.ev = 8'h00;
        steps(3);

        // Two channels on one code, inverted polarity on ch2.
        set_ch(0, 8'h11, 2, 3, 1'b0);
        set_ch(2, 8'h11, 7, 3, 1'b1);
        fire(8'h11);
        steps(12);

        // Per-channel abort during ACTIVE, and global enable blocking.
        set_ch(0, 8'h50, 1, 10, 1'b0);
        fire(8'h50);
        steps(4);
        bus.ch_ena[0] = 1'b0;
        steps(2);
        bus.ch_ena[0] = 1'b1;
        steps(2);
        set_ch(0, 8'h51, 4, 10, 1'b0);
        fire(8'h51);
        steps(6);
        bus.ena = 1'b0;
        fire(8'h51);
        steps(3);
        bus.ena = 1'b1;
        steps(8);

        // Reset mid-DELAY and mid-ACTIVE.
        set_ch(0, 8'h60, 8, 5, 1'b0);
        set_ch(2, 8'h60, 8, 5, 1'b1);
        fire(8'h60);
        steps(3);
        do_reset();
        steps(15);
        set_ch(0, 8'h61, 1, 5, 1'b1);
        fire(8'h61);
        steps(4);
        do_reset();
        steps(8);

        // Code 0 with idle events never fires.
        set_ch(3, 8'h00, 0, 2, 1'b0);
        steps(5);

        // Full-width and full-delay values latched then aborted.
        set_ch(3, 8'h44, 0, {WID_W{1'b1}}, 1'b0);
        fire(8'h44);
        steps(20);
        bus.ch_ena[3] = 1'b0;
        steps(2);
        bus.ch_ena[3] = 1'b1;
        set_ch(3, 8'h45, {DLY_W{1'b1}}, 1, 1'b0);
        fire(8'h45);
        steps(20);
        bus.ch_ena[3] = 1'b0;
        steps(2);
        bus.ch_ena[3] = 1'b1;
        steps(2);

        // Randomized traffic.
        for (int i = 0; i < NUM_CH; i++) begin
            set_ch(i, code_set[$urandom_range(0, 3)], DLY_W'($urandom_range(0, 12)),
                   WID_W'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                c = $urandom_range(0, NUM_CH - 1);
                set_ch(c, code_set[$urandom_range(0, 3)], DLY_W'($urandom_range(0, 12)),
                       WID_W'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 1) == 0)
                bus.ev = 8'h00;
            else if ($urandom_range(0, 7) == 0)
                bus.ev = 8'($urandom);
            else
                bus.ev = code_set[$urandom_range(0, 3)];
            if ($urandom_range(0, 31) == 0) bus.ena = ~bus.ena;
            if ($urandom_range(0, 39) == 0) begin
                c = $urandom_range(0, NUM_CH - 1);
                bus.ch_ena[c] = ~bus.ch_ena[c];
            end
            bus.missed_clr = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
            if (n == 1000) do_reset();
            step();
        end
        bus.ev = 8'h00;
        steps(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
